// File: rtl/serial_add_ctrl_pkg.sv
// Shared constants for the bit-serial adder controller: state encoding and default width.
package serial_add_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   localparam int SADD_WIDTH = 8;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// Combinational 1-bit full adder, time-shared by the serial adder controller.
module fa (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic co,
   output logic s
);

   assign s  = a ^ b ^ cin;
   assign co = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first through one fa cell.
// Optional macro SERIAL_ADD_SUB_EN adds a `sub` port for two's-complement subtraction.
//
// state   | meaning
// --------+-----------------------------------------------
// ST_IDLE | waiting for start; sum/cout hold last result
// ST_RUN  | one operand bit per clock through fa (busy=1)
// ST_DONE | single-cycle done pulse; start accepted here
module serial_add_ctrl
   import serial_add_ctrl_pkg::*;
#(
   parameter  int WIDTH = SADD_WIDTH,
   localparam int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef SERIAL_ADD_SUB_EN
   input  logic             sub,
`endif
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   state_t             state;
   state_t             state_nxt;
   logic [WIDTH-1:0]   a_sh;
   logic [WIDTH-1:0]   b_sh;
   logic [WIDTH-1:0]   sum_sh;
   logic               c;
   logic [CNT_W-1:0]   cnt;
   logic               load;
   logic               shift;
   logic               last;
   logic               fa_s;
   logic               fa_co;
   logic [WIDTH-1:0]   b_ld;
   logic               c_ld;

`ifdef SERIAL_ADD_SUB_EN
   // Subtraction is a + ~b + 1; cout=1 then means no borrow.
   assign b_ld = sub ? ~b : b;
   assign c_ld = sub ? 1'b1 : cin;
`else
   assign b_ld = b;
   assign c_ld = cin;
`endif

   fa u_fa (
      .a   (a_sh[0]),
      .b   (b_sh[0]),
      .cin (c),
      .co  (fa_co),
      .s   (fa_s)
   );

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      shift     = 1'b0;
      last      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = ST_RUN;
            end
         end
         ST_RUN: begin
            shift = 1'b1;
            if (cnt == CNT_W'(WIDTH - 1)) begin
               last      = 1'b1;
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = ST_RUN;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         sum_sh <= '0;
         c      <= 1'b0;
         cnt    <= '0;
         sum    <= '0;
         cout   <= 1'b0;
      end else begin
         if (load) begin
            a_sh <= a;
            b_sh <= b_ld;
            c    <= c_ld;
            cnt  <= '0;
         end else if (shift) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
            c      <= fa_co;
            cnt    <= cnt + CNT_W'(1);
         end
         // Result registers only move on the final bit, so they hold through IDLE.
         if (last) begin
            sum  <= {fa_s, sum_sh[WIDTH-1:1]};
            cout <= fa_co;
         end
      end
   end

   assign busy = (state == ST_RUN);
   assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed self-checking bench for serial_add_ctrl (WIDTH=8); sub tests under SERIAL_ADD_SUB_EN.
module tb_serial_add_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       cin = 1'b0;
`ifdef SERIAL_ADD_SUB_EN
   logic       sub = 1'b0;
`endif
   logic       busy;
   logic       done;
   logic [7:0] sum;
   logic       cout;

   int vectors = 0;
   int errs    = 0;

   always #5 clk = ~clk;

   serial_add_ctrl #(.WIDTH(8)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .a     (a),
      .b     (b),
      .cin   (cin),
`ifdef SERIAL_ADD_SUB_EN
      .sub   (sub),
`endif
      .busy  (busy),
      .done  (done),
      .sum   (sum),
      .cout  (cout)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accept a start, verify busy for 8 cycles, then done with the expected result.
   task automatic run_op(input string tag, input logic [7:0] va, input logic [7:0] vb,
                         input logic vc, input logic [7:0] es, input logic ec,
                         input bit scramble);
      a = va; b = vb; cin = vc; start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         check({tag, "_busy"}, {busy, done}, 2'b10);
         if (scramble) begin
            a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            start = 1'($urandom);
         end
         step();
      end
      start = 1'b0;
      check({tag, "_done"}, {busy, done}, 2'b01);
      check({tag, "_result"}, {cout, sum}, {ec, es});
      step();
      check({tag, "_idle"}, {busy, done}, 2'b00);
      check({tag, "_hold"}, {cout, sum}, {ec, es});
   endtask

   initial begin
      int gap;
      bit seen;

      rst = 1'b1;
      step(); step();
      rst = 1'b0;
      check("reset", {busy, done, cout, sum}, 11'h000);

      run_op("add_3c_42", 8'h3C, 8'h42, 1'b0, 8'h7E, 1'b0, 1'b0);
      run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
      run_op("add_ff_ff_c", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);

      // Held-in-IDLE result persists several cycles.
      step(); step(); step();
      check("idle_hold", {cout, sum}, 9'h1FF);

      // Back-to-back with start held high; operands swapped right after acceptance.
      a = 8'h10; b = 8'h20; cin = 1'b0; start = 1'b1;
      step();
      a = 8'h05; b = 8'h06;
      gap = 0;
      while (!done && gap < 20) begin step(); gap++; end
      check("b2b_first_lat", gap, 8);
      check("b2b_first_sum", {cout, sum}, 9'h030);
      gap = 0;
      step(); gap++;
      check("b2b_rerun_busy", {busy, done}, 2'b10);
      while (!done && gap < 20) begin step(); gap++; end
      start = 1'b0;
      check("b2b_spacing", gap, 9);
      check("b2b_second_sum", {cout, sum}, 9'h00B);
      step();
      check("b2b_idle", {busy, done}, 2'b00);

      // Reset mid-RUN discards the operation.
      a = 8'hAA; b = 8'h55; cin = 1'b1; start = 1'b1;
      step();
      start = 1'b0;
      step(); step(); step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_state", {busy, done, cout, sum}, 11'h000);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (done) seen = 1'b1;
         step();
      end
      check("midrst_no_done", seen, 1'b0);
      run_op("after_rst", 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

      // rst wins over start in the same cycle.
      rst = 1'b1; start = 1'b1; a = 8'h01; b = 8'h01;
      step();
      rst = 1'b0; start = 1'b0;
      check("rst_vs_start", {busy, done, cout, sum}, 11'h000);

      // Operands and start thrash during RUN; captured values must be used.
      run_op("scramble", 8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1, 1'b1);
      run_op("scramble2", 8'h9C, 8'h37, 1'b1, 8'hD4, 1'b0, 1'b1);

`ifdef SERIAL_ADD_SUB_EN
      sub = 1'b1;
      run_op("sub_50_20", 8'h50, 8'h20, 1'b0, 8'h30, 1'b1, 1'b0);
      run_op("sub_20_50", 8'h20, 8'h50, 1'b1, 8'hD0, 1'b0, 1'b0);
      sub = 1'b0;
      run_op("sub0_add", 8'h20, 8'h50, 1'b1, 8'h71, 1'b0, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
